// File: rtl/demod_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module : demod_sched_pkg
// Desc   : Shared types, pilot-bin constants and bin classifier for demod_sched
// Rev    : 1.0 - initial release
// ============================================================================
package demod_sched_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      DC    = 2'd0,
      GUARD = 2'd1,
      PILOT = 2'd2,
      DATA  = 2'd3
   } bin_class_t;

   localparam int unsigned c_pilot_0 = 7;
   localparam int unsigned c_pilot_1 = 21;
   localparam int unsigned c_pilot_2 = 43;
   localparam int unsigned c_pilot_3 = 57;

   // Four 2-bit symbols per byte, so the slot counter is 2 bits wide
   localparam int unsigned c_slot_w = 2;

   function automatic bin_class_t bin_class(input int unsigned bin,
                                            input int unsigned guard_lo,
                                            input int unsigned guard_hi);
      bin_class_t cls;
      if (bin == 0)
         cls = DC;
      else if (bin >= guard_lo && bin <= guard_hi)
         cls = GUARD;
      else if (bin == c_pilot_0 || bin == c_pilot_1 || bin == c_pilot_2 || bin == c_pilot_3)
         cls = PILOT;
      else
         cls = DATA;
      return cls;
   endfunction

endpackage
`default_nettype wire

// File: rtl/demod_sched_sym_packer.sv
`default_nettype none
// ============================================================================
// Module : demod_sched_sym_packer
// Desc   : Packs 2-bit demod symbols MSB-first into bytes; flushes a partial byte
// Rev    : 1.0 - initial release
// ============================================================================
module demod_sched_sym_packer
   import demod_sched_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       clear,
   input  logic       sym_valid,
   input  logic [1:0] sym,
   input  logic       flush,
   output logic [7:0] byte_out,
   output logic       byte_valid,
   output logic       idle
);

   logic [c_slot_w-1:0] r_slot;
   logic [7:0]          r_acc;
   logic [7:0]          r_byte;
   logic                r_byte_valid;
   logic [7:0]          w_shifted;
   logic [7:0]          w_padded;

   assign w_shifted = {r_acc[5:0], sym};

   // Left-justify a partial byte so its first symbol still lands in [7:6]
   always_comb begin
      w_padded = r_acc;
      case (r_slot)
         2'd1:    w_padded = {r_acc[1:0], 6'b0};
         2'd2:    w_padded = {r_acc[3:0], 4'b0};
         2'd3:    w_padded = {r_acc[5:0], 2'b0};
         default: w_padded = r_acc;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_slot       <= '0;
         r_acc        <= '0;
         r_byte       <= '0;
         r_byte_valid <= 1'b0;
      end else if (clear) begin
         r_slot       <= '0;
         r_acc        <= '0;
         r_byte_valid <= 1'b0;
      end else begin
         r_byte_valid <= 1'b0;
         if (sym_valid) begin
            if (&r_slot) begin
               r_byte       <= w_shifted;
               r_byte_valid <= 1'b1;
               r_acc        <= '0;
               r_slot       <= '0;
            end else begin
               r_acc  <= w_shifted;
               r_slot <= r_slot + 1'b1;
            end
         end else if (flush && r_slot != '0) begin
            r_byte       <= w_padded;
            r_byte_valid <= 1'b1;
            r_acc        <= '0;
            r_slot       <= '0;
         end
      end
   end

   assign byte_out   = r_byte;
   assign byte_valid = r_byte_valid;
   assign idle       = (r_slot == '0);

endmodule
`default_nettype wire

// File: rtl/demod_sched.sv
`default_nettype none
// ============================================================================
// Module : demod_sched
// Desc   : OFDM subcarrier scheduler: routes data/pilot bins, packs demod bytes
// Rev    : 1.0 - initial release
// ============================================================================
module demod_sched
   import demod_sched_pkg::*;
#(
   parameter int unsigned NFFT           = 64,
   parameter int unsigned GUARD_LO       = 27,
   parameter int unsigned GUARD_HI       = 37,
   parameter int unsigned SYMS_PER_FRAME = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               fft_valid,
   input  logic               fft_sop,
   input  logic signed [15:0] fft_i,
   input  logic signed [15:0] fft_q,
   output logic signed [15:0] dm_i,
   output logic signed [15:0] dm_q,
   output logic               dm_valid,
   input  logic [1:0]         dm_sym,
   input  logic               dm_valid_d,
   output logic signed [15:0] pilot_i,
   output logic signed [15:0] pilot_q,
   output logic               pilot_valid,
   output logic [7:0]         byte_out,
   output logic               byte_valid,
   output logic               busy,
   output logic               frame_done,
   output logic               sop_err
);

   localparam int unsigned    BW         = $clog2(NFFT);
   localparam logic [BW-1:0]  c_bin_last = BW'(NFFT - 1);
   localparam logic [7:0]     c_syms     = 8'(SYMS_PER_FRAME);

   state_t             r_state;
   logic [BW-1:0]      r_bin_cnt;
   logic [7:0]         r_sym_cnt;
   logic [7:0]         r_outstanding;
   logic               r_busy;
   logic               r_frame_done;
   logic               r_sop_err;
   logic               r_dm_valid;
   logic               r_pilot_valid;
   logic signed [15:0] r_dm_i;
   logic signed [15:0] r_dm_q;
   logic signed [15:0] r_pilot_i;
   logic signed [15:0] r_pilot_q;

   logic [BW-1:0]      w_bin;
   bin_class_t         w_class;
   logic               w_start_ok;
   logic               w_issue;
   logic               w_ret;
   logic               w_flush;
   logic               w_pk_idle;

   // An sop always resyncs the bin counter, aligned or not
   assign w_bin      = fft_sop ? '0 : r_bin_cnt;
   assign w_class    = bin_class(32'(w_bin), GUARD_LO, GUARD_HI);
   assign w_start_ok = (r_state == IDLE) && start && !r_frame_done;
   assign w_issue    = (r_state == RUN) && fft_valid && (w_class == DATA);
   assign w_ret      = dm_valid_d && (r_state != IDLE);
   assign w_flush    = (r_state == DRAIN) && (r_outstanding == '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= IDLE;
         r_bin_cnt     <= '0;
         r_sym_cnt     <= '0;
         r_busy        <= 1'b0;
         r_frame_done  <= 1'b0;
         r_sop_err     <= 1'b0;
         r_dm_valid    <= 1'b0;
         r_pilot_valid <= 1'b0;
         r_dm_i        <= '0;
         r_dm_q        <= '0;
         r_pilot_i     <= '0;
         r_pilot_q     <= '0;
      end else begin
         r_dm_valid    <= 1'b0;
         r_pilot_valid <= 1'b0;
         r_frame_done  <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_start_ok) begin
                  r_state   <= RUN;
                  r_busy    <= 1'b1;
                  r_bin_cnt <= '0;
                  r_sym_cnt <= '0;
                  r_sop_err <= 1'b0;
               end
            end
            RUN: begin
               if (fft_valid) begin
                  if (fft_sop && r_bin_cnt != '0)
                     r_sop_err <= 1'b1;
                  if (w_class == DATA) begin
                     r_dm_valid <= 1'b1;
                     r_dm_i     <= fft_i;
                     r_dm_q     <= fft_q;
                  end
                  if (w_class == PILOT) begin
                     r_pilot_valid <= 1'b1;
                     r_pilot_i     <= fft_i;
                     r_pilot_q     <= fft_q;
                  end
                  if (w_bin == c_bin_last) begin
                     r_bin_cnt <= '0;
                     r_sym_cnt <= r_sym_cnt + 8'd1;
                     if (r_sym_cnt + 8'd1 == c_syms)
                        r_state <= DRAIN;
                  end else begin
                     r_bin_cnt <= w_bin + 1'b1;
                  end
               end
            end
            DRAIN: begin
               if (r_outstanding == '0 && w_pk_idle) begin
                  r_state      <= IDLE;
                  r_busy       <= 1'b0;
                  r_frame_done <= 1'b1;
               end
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   // Demod results still in flight; DRAIN waits for this to empty
   always_ff @(posedge clk) begin
      if (rst || w_start_ok) begin
         r_outstanding <= '0;
      end else begin
         case ({w_issue, w_ret})
            2'b10:   r_outstanding <= r_outstanding + 8'd1;
            2'b01:   if (r_outstanding != '0) r_outstanding <= r_outstanding - 8'd1;
            default: ;
         endcase
      end
   end

   demod_sched_sym_packer u_packer (
      .clk        (clk),
      .rst        (rst),
      .clear      (w_start_ok),
      .sym_valid  (w_ret),
      .sym        (dm_sym),
      .flush      (w_flush),
      .byte_out   (byte_out),
      .byte_valid (byte_valid),
      .idle       (w_pk_idle)
   );

   assign dm_i        = r_dm_i;
   assign dm_q        = r_dm_q;
   assign dm_valid    = r_dm_valid;
   assign pilot_i     = r_pilot_i;
   assign pilot_q     = r_pilot_q;
   assign pilot_valid = r_pilot_valid;
   assign busy        = r_busy;
   assign frame_done  = r_frame_done;
   assign sop_err     = r_sop_err;

endmodule
`default_nettype wire

// File: doc/demod_sched.md
# demod_sched

Subcarrier scheduler and symbol packer between the FFT output and the QPSK demodulator in the OFDM receiver chain. It tracks the bin index of each OFDM symbol and forwards only data subcarriers to the demodulator. Pilot bins go to a side port for channel estimation; guard and DC bins are dropped. Returned 2-bit symbols are packed into bytes, and a frame of SYMS_PER_FRAME OFDM symbols is sequenced from start to completion.

## Interface
- NFFT, 64: FFT size; bins arrive in natural order, with bin 0 = DC.
- GUARD_LO, 27: first guard bin; guard bins run GUARD_LO..GUARD_HI inclusive.
- GUARD_HI, 37: last guard bin.
- SYMS_PER_FRAME, 4: OFDM symbols per frame, range 1..255.
- clk  in  1  clock. One clock domain; reset is synchronous and active-high.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle pulse that begins a frame; honoured only in IDLE.
- fft_valid  in  1  fft_i/fft_q hold a valid bin.
- fft_sop  in  1  qualified by fft_valid; marks bin 0 of an OFDM symbol.
- fft_i, fft_q  in  16 signed  FFT output sample.
- dm_i, dm_q  out  16 signed  sample to the demodulator.
- dm_valid  out  1  data-valid to the demodulator.
- dm_sym  in  2  symbol from the demodulator.
- dm_valid_d  in  1  demodulator result valid; arrives 1 cycle after dm_valid.
- pilot_i, pilot_q  out  16 signed  pilot sample.
- pilot_valid  out  1  pilot strobe.
- byte_out  out  8  packed symbols; the first symbol goes in [7:6].
- byte_valid  out  1  one-cycle strobe for byte_out.
- busy  out  1  high in RUN or DRAIN.
- frame_done  out  1  one-cycle pulse at the end of a frame.
- sop_err  out  1  sticky; set on a misaligned sop; cleared by start or rst.

## Operation
- **Bin classes.**
  - DC: bin 0.
  - Guard: bins GUARD_LO..GUARD_HI.
  - Pilot: bins 7, 21, 43, 57; these are constants in the package.
  - Data: every other bin. Default parameters give 48 data bins, which is 12 bytes per OFDM symbol.
- **States.**
  - IDLE: fft_valid is ignored. start moves to RUN and clears the bin counter, symbol counter, pack register and sop_err.
  - RUN: every fft_valid advances bin_cnt, which wraps at NFFT-1 → 0.
    - Data bin: drive dm_*.
    - Pilot bin: drive pilot_*.
    - When the bin at NFFT-1 is accepted, sym_cnt increments. When sym_cnt reaches SYMS_PER_FRAME, move to DRAIN.
  - DRAIN: fft_valid is ignored. Wait until the outstanding counter (dm_valid issued minus dm_valid_d received) is 0 and the final byte has been emitted. Then pulse frame_done for 1 cycle and return to IDLE.
- **SOP alignment.**
  - fft_sop with bin_cnt≠0: set sop_err and treat the bin as bin 0, i.e. resync.
  - bin_cnt=0 without fft_sop: accepted as bin 0, with no error.
- **Packing.**
  - A 2-bit slot counter counts dm_valid_d strobes. Symbols shift in MSB-first.
  - On the 4th symbol, byte_valid is asserted and the slot counter wraps to 0.
  - A partial byte never occurs with the default parameters. If non-default parameters leave one in DRAIN, it is zero-padded in the low bits and emitted before frame_done.
- **Simultaneous events.**
  - start while busy: ignored.
  - start in the same cycle as frame_done: ignored. The next start must come in IDLE.
  - dm_valid_d outside RUN/DRAIN: dropped.
- **Reset.**
  - rst mid-frame returns to IDLE on the next edge and discards any partial byte.
  - All outputs reset to 0, and the state resets to IDLE.

## Timing
- All outputs are registered.
- A bin accepted with fft_valid in cycle t appears on dm_* or pilot_* in cycle t+1.
- The demod result arrives in t+2. The byte containing it is strobed in t+3 when it fills the 4th slot.
- Throughput is 1 bin per cycle with no stall. There is no backpressure on the byte output; the consumer must accept every strobe.
- frame_done comes no earlier than 1 cycle after the last byte_valid.
- dm_i/dm_q and pilot_i/pilot_q hold their last values when their strobe is low.

## Structure
- Package demod_sched_pkg holds:
  - the state enum (IDLE, RUN, DRAIN);
  - the bin-class enum (DC, GUARD, PILOT, DATA);
  - the pilot-bin constants;
  - function bin_class(bin, GUARD_LO, GUARD_HI).
- One sub-module, sym_packer: the 2-bit shift/slot counter, byte strobe and flush on DRAIN.
- The classifier, counters and FSM sit in the top level. The existing demod instance is external.

## Test plan
- **Full frame.** start, then 4×64 valid bins with sop on bin 0 and I/Q = bin index. Required: exactly 192 dm_valid pulses, 16 pilot_valid pulses, no strobe on bins 0 or 27..37, 48 byte_valid pulses, and a single frame_done after the last byte.
- **Packing order.** Loop back a demod model returning symbols 3,1,2,0 repeating. Required: byte_out = 8'hD8 on every strobe.
- **Gapped input.** Same frame as the first test with fft_valid low on alternate cycles. Required: identical outputs and counts, with bytes spaced accordingly.
- **Misaligned sop.** sop on bin 10 of the 2nd symbol. Required: sop_err=1 and bin_cnt resyncs to 0. The frame ends after 4 sop-aligned symbol completions, and sop_err stays high until the next start.
- **Reset mid-frame.** rst after 100 bins. Required: the next cycle shows busy=0 with all outputs 0. fft_valid in IDLE produces no strobes. A fresh start then runs a clean frame.
- **start while busy.** start at bin 30 of symbol 1. Required: ignored, with no counter reset.
